// File: rtl/mem_stage.sv
// Memory-access stage: holds the instruction from execute, waits for its data-SRAM response,
// aligns/extends load data and drops responses of flushed requests. Optional macro: MS_LOAD_FWD_EN.
module mem_stage #(
   parameter int DROP_CNT_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        es_to_ms_valid,
   output logic        ms_allowin,
   input  logic [31:0] es_pc,
   input  logic [31:0] es_result,
   input  logic [4:0]  es_dest,
   input  logic        es_gr_we,
   input  logic        es_res_from_mem,
   input  logic        es_mem_req,
   input  logic [4:0]  es_load_op,
   input  logic        es_ex,
   input  logic        ms_flush,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        ws_allowin,
   output logic        ms_to_ws_valid,
   output logic [31:0] ms_pc,
   output logic [31:0] ms_final_result,
   output logic [4:0]  ms_dest,
   output logic        ms_gr_we,
   output logic        ms_ex_out,
   output logic        ms_fwd_valid,
   output logic        ms_fwd_blk,
   output logic [4:0]  ms_fwd_dest,
   output logic [31:0] ms_fwd_data
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;
   localparam logic [DROP_CNT_W-1:0] DROP_ZERO = '0;
   localparam logic [DROP_CNT_W-1:0] DROP_ONE  = DROP_CNT_W'(1);

   state_t                 state, state_nxt;
   logic                   ms_valid;
   logic [31:0]            result_q;
   logic                   gr_we_q;
   logic                   res_from_mem_q;
   logic [4:0]             load_op_q;
   logic                   ex_q;
   logic [31:0]            buf_q;
   logic [DROP_CNT_W-1:0]  drop_cnt;

   logic        capture;
   logic        ms_ready_go;
   logic        accept;
   logic        leave;
   logic        drop_inc;
   logic        drop_dec;
   logic        fwd_ready;
   logic [31:0] rdata_sel;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_val;

   assign capture        = (state == S_WAIT) && data_sram_data_ok && (drop_cnt == DROP_ZERO);
   assign ms_ready_go    = (state == S_IDLE) || (state == S_HOLD) || capture;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign accept         = es_to_ms_valid && ms_allowin;
   assign leave          = ms_valid && ms_ready_go && ws_allowin;
   assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;

   // A flushed request still outstanding in WAIT will return data that must be discarded.
   assign drop_inc = ms_flush && (state == S_WAIT) && !capture;
   assign drop_dec = data_sram_data_ok && (drop_cnt != DROP_ZERO);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ms_flush)
         state_nxt = S_IDLE;
      else if (accept)
         state_nxt = (es_mem_req && !es_ex) ? S_WAIT : S_IDLE;
      else if (leave)
         state_nxt = S_IDLE;
      else if (capture)
         state_nxt = S_HOLD;
   end

   always_ff @(posedge clk) begin
      if (reset)              ms_valid <= 1'b0;
      else if (ms_flush)      ms_valid <= 1'b0;
      else if (ms_allowin)    ms_valid <= es_to_ms_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_pc          <= 32'h0;
         result_q       <= 32'h0;
         ms_dest        <= 5'h0;
         gr_we_q        <= 1'b0;
         res_from_mem_q <= 1'b0;
         load_op_q      <= 5'h0;
         ex_q           <= 1'b0;
      end else if (accept) begin
         ms_pc          <= es_pc;
         result_q       <= es_result;
         ms_dest        <= es_dest;
         gr_we_q        <= es_gr_we;
         res_from_mem_q <= es_res_from_mem;
         load_op_q      <= es_load_op;
         ex_q           <= es_ex;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)        buf_q <= 32'h0;
      else if (capture) buf_q <= data_sram_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt <= DROP_ZERO;
      else if (drop_inc && !drop_dec && (drop_cnt != DROP_MAX))
         drop_cnt <= drop_cnt + DROP_ONE;
      else if (drop_dec && !drop_inc)
         drop_cnt <= drop_cnt - DROP_ONE;
   end

   a_drop_no_sat: assert property (@(posedge clk) disable iff (reset)
      !(drop_inc && !drop_dec && (drop_cnt == DROP_MAX)));

   // In the capture cycle the buffer is not yet written, so align the live response.
   assign rdata_sel = capture ? data_sram_rdata : buf_q;

   always_comb begin
      byte_v = rdata_sel[7:0];
      case (result_q[1:0])
         2'd1:    byte_v = rdata_sel[15:8];
         2'd2:    byte_v = rdata_sel[23:16];
         2'd3:    byte_v = rdata_sel[31:24];
         default: byte_v = rdata_sel[7:0];
      endcase
      half_v = result_q[1] ? rdata_sel[31:16] : rdata_sel[15:0];

      load_val = rdata_sel;
      if (load_op_q[0])      load_val = {{24{byte_v[7]}}, byte_v};
      else if (load_op_q[1]) load_val = {{16{half_v[15]}}, half_v};
      else if (load_op_q[3]) load_val = {24'h0, byte_v};
      else if (load_op_q[4]) load_val = {16'h0, half_v};
   end

   assign ms_final_result = res_from_mem_q ? load_val : result_q;

`ifdef MS_LOAD_FWD_EN
   assign fwd_ready = capture || (state == S_HOLD);
`else
   assign fwd_ready = (state == S_HOLD);
`endif

   assign ms_ex_out    = ms_valid && ex_q;
   assign ms_gr_we     = gr_we_q && !ms_ex_out;
   assign ms_fwd_valid = ms_valid && ms_gr_we && (ms_dest != 5'd0);
   assign ms_fwd_blk   = ms_valid && res_from_mem_q && !fwd_ready;
   assign ms_fwd_dest  = ms_dest;
   assign ms_fwd_data  = ms_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, SRAM wait/hold, flush with stale-response drop,
// pass-through ALU results and exception-carrying loads (default build, forwarding option off).
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        es_to_ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc;
   logic [31:0] es_result;
   logic [4:0]  es_dest;
   logic        es_gr_we;
   logic        es_res_from_mem;
   logic        es_mem_req;
   logic [4:0]  es_load_op;
   logic        es_ex;
   logic        ms_flush;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic [31:0] ms_final_result;
   logic [4:0]  ms_dest;
   logic        ms_gr_we;
   logic        ms_ex_out;
   logic        ms_fwd_valid;
   logic        ms_fwd_blk;
   logic [4:0]  ms_fwd_dest;
   logic [31:0] ms_fwd_data;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [4:0] LD_B  = 5'b00001;
   localparam logic [4:0] LD_H  = 5'b00010;
   localparam logic [4:0] LD_W  = 5'b00100;
   localparam logic [4:0] LD_BU = 5'b01000;
   localparam logic [4:0] LD_HU = 5'b10000;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .es_to_ms_valid    (es_to_ms_valid),
      .ms_allowin        (ms_allowin),
      .es_pc             (es_pc),
      .es_result         (es_result),
      .es_dest           (es_dest),
      .es_gr_we          (es_gr_we),
      .es_res_from_mem   (es_res_from_mem),
      .es_mem_req        (es_mem_req),
      .es_load_op        (es_load_op),
      .es_ex             (es_ex),
      .ms_flush          (ms_flush),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_pc             (ms_pc),
      .ms_final_result   (ms_final_result),
      .ms_dest           (ms_dest),
      .ms_gr_we          (ms_gr_we),
      .ms_ex_out         (ms_ex_out),
      .ms_fwd_valid      (ms_fwd_valid),
      .ms_fwd_blk        (ms_fwd_blk),
      .ms_fwd_dest       (ms_fwd_dest),
      .ms_fwd_data       (ms_fwd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                       input logic we, input logic mem, input logic req, input logic [4:0] op,
                       input logic ex);
      es_pc = pc; es_result = res; es_dest = dest; es_gr_we = we;
      es_res_from_mem = mem; es_mem_req = req; es_load_op = op; es_ex = ex;
      es_to_ms_valid = 1'b1;
      tick();
      es_to_ms_valid = 1'b0;
      es_mem_req = 1'b0;
   endtask

   // Load answered one cycle after accept, held one cycle in HOLD, then drained.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [4:0] op,
                          input logic [31:0] rdata, input logic [31:0] expv);
      ws_allowin = 1'b0;
      send(32'h1c00_0100, addr, 5'd4, 1'b1, 1'b1, 1'b1, op, 1'b0);
      chk({tag, "_wait_blk"}, 32'(ms_fwd_blk), 32'd1);
      chk({tag, "_wait_tws"}, 32'(ms_to_ws_valid), 32'd0);
      data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
      #1;
      chk({tag, "_cap_tws"}, 32'(ms_to_ws_valid), 32'd1);
      chk({tag, "_cap_res"}, ms_final_result, expv);
      chk({tag, "_cap_blk"}, 32'(ms_fwd_blk), 32'd1);
      tick();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      #1;
      chk({tag, "_hold_res"}, ms_final_result, expv);
      chk({tag, "_hold_fwd"}, ms_fwd_data, expv);
      chk({tag, "_hold_blk"}, 32'(ms_fwd_blk), 32'd0);
      ws_allowin = 1'b1;
      tick();
      chk({tag, "_done_tws"}, 32'(ms_to_ws_valid), 32'd0);
      ws_allowin = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int xfers;
      reset = 1'b1; es_to_ms_valid = 1'b0; es_pc = 32'h0; es_result = 32'h0; es_dest = 5'h0;
      es_gr_we = 1'b0; es_res_from_mem = 1'b0; es_mem_req = 1'b0; es_load_op = 5'h0;
      es_ex = 1'b0; ms_flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      ws_allowin = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      chk("rst_allowin", 32'(ms_allowin), 32'd1);
      chk("rst_tws", 32'(ms_to_ws_valid), 32'd0);
      chk("rst_fwd_valid", 32'(ms_fwd_valid), 32'd0);
      chk("rst_fwd_blk", 32'(ms_fwd_blk), 32'd0);
      chk("rst_ex", 32'(ms_ex_out), 32'd0);
      chk("rst_pc", ms_pc, 32'h0);
      chk("rst_res", ms_final_result, 32'h0);

      do_load("ldb",  32'h0000_1003, LD_B,  32'h80FF_0000, 32'hFFFF_FF80);
      do_load("ldbu", 32'h0000_1003, LD_BU, 32'h80FF_0000, 32'h0000_0080);
      do_load("ldbu1", 32'h0000_1001, LD_BU, 32'h1234_5678, 32'h0000_0056);
      do_load("ldb2", 32'h0000_1002, LD_B,  32'h12F4_5678, 32'hFFFF_FFF4);
      do_load("ldh",  32'h0000_2002, LD_H,  32'h8001_1234, 32'hFFFF_8001);
      do_load("ldhu", 32'h0000_2002, LD_HU, 32'h8001_1234, 32'h0000_8001);
      do_load("ldh0", 32'h0000_2000, LD_H,  32'h8001_9234, 32'hFFFF_9234);
      do_load("ldw",  32'h0000_2004, LD_W,  32'hCAFE_F00D, 32'hCAFE_F00D);

      // Slow response, then writeback stalls for four cycles.
      ws_allowin = 1'b0;
      send(32'h1c00_0200, 32'h0000_3000, 5'd6, 1'b1, 1'b1, 1'b1, LD_W, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("slow_wait_allowin", 32'(ms_allowin), 32'd0);
         chk("slow_wait_tws", 32'(ms_to_ws_valid), 32'd0);
         tick();
      end
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7654_3210;
      #1;
      chk("slow_cap_allowin", 32'(ms_allowin), 32'd0);
      tick();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         chk("slow_hold_res", ms_final_result, 32'h7654_3210);
         chk("slow_hold_allowin", 32'(ms_allowin), 32'd0);
         chk("slow_hold_tws", 32'(ms_to_ws_valid), 32'd1);
         tick();
      end
      ws_allowin = 1'b1;
      xfers = 0;
      for (int i = 0; i < 3; i++) begin
         if (ms_to_ws_valid && ws_allowin) xfers++;
         tick();
      end
      chk("slow_xfers", 32'(xfers), 32'd1);
      ws_allowin = 1'b0;

      // Flush while waiting: the first response belongs to the killed load.
      send(32'h1c00_0300, 32'h0000_4000, 5'd8, 1'b1, 1'b1, 1'b1, LD_W, 1'b0);
      ms_flush = 1'b1;
      #1;
      chk("flush_tws", 32'(ms_to_ws_valid), 32'd0);
      tick();
      ms_flush = 1'b0;
      #1;
      chk("flush_allowin", 32'(ms_allowin), 32'd1);
      send(32'h1c00_0304, 32'h0000_5000, 5'd9, 1'b1, 1'b1, 1'b1, LD_W, 1'b0);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
      #1;
      chk("drop_tws", 32'(ms_to_ws_valid), 32'd0);
      tick();
      data_sram_rdata = 32'h0000_BEEF;
      #1;
      chk("after_drop_tws", 32'(ms_to_ws_valid), 32'd1);
      chk("after_drop_res", ms_final_result, 32'h0000_BEEF);
      tick();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      #1;
      chk("after_drop_hold", ms_final_result, 32'h0000_BEEF);
      chk("after_drop_pc", ms_pc, 32'h1c00_0304);
      // Leave HOLD and accept the next load in the same cycle.
      ws_allowin = 1'b1;
      send(32'h1c00_0308, 32'h0000_6000, 5'd10, 1'b1, 1'b1, 1'b1, LD_W, 1'b0);
      ws_allowin = 1'b0;
      chk("b2b_tws", 32'(ms_to_ws_valid), 32'd0);
      chk("b2b_blk", 32'(ms_fwd_blk), 32'd1);
      chk("b2b_pc", ms_pc, 32'h1c00_0308);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
      #1;
      chk("b2b_res", ms_final_result, 32'h1111_2222);
      ws_allowin = 1'b1;
      tick();
      data_sram_data_ok = 1'b0;
      chk("b2b_done_tws", 32'(ms_to_ws_valid), 32'd0);

      // Plain ALU result passes straight through.
      send(32'h1c00_0010, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0);
      chk("add_tws", 32'(ms_to_ws_valid), 32'd1);
      chk("add_fwd_valid", 32'(ms_fwd_valid), 32'd1);
      chk("add_fwd_blk", 32'(ms_fwd_blk), 32'd0);
      chk("add_fwd_data", ms_fwd_data, 32'h0000_1234);
      chk("add_fwd_dest", 32'(ms_fwd_dest), 32'd5);
      chk("add_pc", ms_pc, 32'h1c00_0010);
      tick();
      chk("add_done_tws", 32'(ms_to_ws_valid), 32'd0);

      // Writes to r0 are not forwarded.
      send(32'h1c00_0014, 32'h0000_5555, 5'd0, 1'b1, 1'b0, 1'b0, 5'h0, 1'b0);
      chk("r0_fwd_valid", 32'(ms_fwd_valid), 32'd0);
      tick();

      // Load already carrying an exception issues no request and does not wait.
      ws_allowin = 1'b0;
      send(32'h1c00_0020, 32'h0000_7001, 5'd7, 1'b1, 1'b1, 1'b0, LD_W, 1'b1);
      chk("ex_tws", 32'(ms_to_ws_valid), 32'd1);
      chk("ex_out", 32'(ms_ex_out), 32'd1);
      chk("ex_gr_we", 32'(ms_gr_we), 32'd0);
      chk("ex_fwd_valid", 32'(ms_fwd_valid), 32'd0);
      ws_allowin = 1'b1;
      tick();
      chk("ex_done_out", 32'(ms_ex_out), 32'd0);
      ws_allowin = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage LoongArch pipeline, directly downstream of the execute stage.
- Accepts one instruction per handshake from execute and waits for the data-SRAM response of any load/store issued there.
- Aligns and extends load data, then hands the final result to writeback.
- Supplies a forwarding/blocking record to decode.
- Discards stale SRAM responses that belong to instructions killed by a pipeline flush.

Parameters:
DROP_CNT_W, 2, width of the stale-response counter; supports up to 2^DROP_CNT_W-1 flushed-but-outstanding requests.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
es_to_ms_valid  input  1  execute has an instruction for this stage
ms_allowin  output  1  this stage can accept this cycle
es_pc  input  32  instruction PC
es_result  input  32  ALU/CSR result; for memory ops, the byte address
es_dest  input  5  destination GPR
es_gr_we  input  1  GPR write enable
es_res_from_mem  input  1  instruction is a load
es_mem_req  input  1  a data-SRAM request was accepted (addr_ok) on the transfer cycle
es_load_op  input  5  one-hot: [0] ld.b, [1] ld.h, [2] ld.w, [3] ld.bu, [4] ld.hu
es_ex  input  1  instruction already carries an exception
ms_flush  input  1  exception/ertn flush from writeback
data_sram_data_ok  input  1  data response valid
data_sram_rdata  input  32  response data
ws_allowin  input  1  writeback can accept
ms_to_ws_valid  output  1  result available to writeback
ms_pc  output  32  held PC
ms_final_result  output  32  aligned load data or passed-through result
ms_dest  output  5  held destination
ms_gr_we  output  1  held write enable, forced 0 when ms_ex_out=1
ms_ex_out  output  1  ms_valid & held es_ex; execute uses it to suppress stores
ms_fwd_valid  output  1  ms_valid & ms_gr_we & dest!=0
ms_fwd_blk  output  1  load whose data is not yet usable; decode must stall
ms_fwd_dest  output  5  forwarding destination
ms_fwd_data  output  32  forwarding value, equal to ms_final_result

Behaviour:
- Reset:
  - ms_valid=0, state=IDLE, drop_cnt=0, data buffer=0.
  - All valid/fwd/ex outputs are 0; data outputs are 0.
- Handshake:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - On es_to_ms_valid & ms_allowin: latch all es_* fields and set ms_valid.
  - ms_to_ws_valid = ms_valid & ms_ready_go & !ms_flush.
- Request tracking:
  - State machine IDLE / WAIT / HOLD.
  - On accept with es_mem_req & !es_ex: go to WAIT. Otherwise go to IDLE, with ms_ready_go=1.
  - In WAIT, a data_ok with drop_cnt==0 captures rdata into the buffer and moves to HOLD. ms_ready_go is 1 in the capture cycle, using live rdata, and in HOLD.
  - Leaving via the writeback handshake returns to IDLE, or to WAIT if a new memory instruction is accepted in the same cycle.
- Flush:
  - ms_flush clears ms_valid next cycle and forces state to IDLE.
  - If the state was WAIT and no data_ok arrives that cycle, drop_cnt increments.
- Drop counter:
  - While drop_cnt>0, each data_ok decrements it and is ignored, even if the state is WAIT.
  - Increment and decrement in the same cycle leave it unchanged.
  - The counter saturates at its maximum; saturation is a verification error (assertion), not wrapped.
- Load alignment, using addr[1:0] = held es_result[1:0]:
  - byte = rdata[8*addr+7 : 8*addr].
  - half = addr[1] ? rdata[31:16] : rdata[15:0].
  - ld.b / ld.bu sign- / zero-extend byte; ld.h / ld.hu sign- / zero-extend half; ld.w passes rdata.
  - Non-load instructions pass es_result through.
- ms_fwd_blk = ms_valid & res_from_mem & !(capture cycle or HOLD). With the optional feature disabled, the capture cycle also blocks.
- Simultaneous accept and flush cannot occur: execute gates its valid on the flush.

Optional Feature:
MS_LOAD_FWD_EN.
- Defined: load data is forwardable in the data_ok cycle, using the live aligned value.
- Undefined: ms_fwd_blk stays 1 until HOLD; forwarding uses only buffered data. This shortens the decode→SRAM timing path at a one-cycle load-use cost.

Test Plan:
- ld.b, addr 0x1003, rdata 0x80FF_0000 → ms_final_result 0xFFFF_FF80; ld.bu same → 0x0000_0080.
- ld.h, addr 0x2002, rdata 0x8001_1234 → 0xFFFF_8001; ld.hu → 0x0000_8001.
- Load with data_ok 3 cycles after accept, ws_allowin held 0 for 4 further cycles → result held stable in HOLD; ms_allowin=0 throughout; one writeback transfer.
- Load in WAIT, ms_flush asserted, next load accepted, then two data_ok (0xDEAD, 0xBEEF) → first dropped, second load completes with 0xBEEF.
- Non-memory add with es_result 0x1234 and ws_allowin=1 → ms_to_ws_valid next cycle; ms_fwd_valid=1, ms_fwd_blk=0, data 0x1234.
- es_ex=1 load (es_mem_req=0) → no wait, ms_ex_out=1, ms_gr_we=0; with MS_LOAD_FWD_EN undefined, a normal load shows ms_fwd_blk=1 in the data_ok cycle.
